// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared FSM encoding and data width for the UART TX feeder
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_feeder_if : system write handshake plus transmitter strobe/data/done
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_tx_feeder_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start_n;
  logic              tx_done;

  modport slave (
    input  wr_data, wr_valid, tx_done,
    output wr_ready, tx_data, tx_start_n
  );

  modport master (
    output wr_data, wr_valid, tx_done,
    input  wr_ready, tx_data, tx_start_n
  );

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_sync_fifo : single-clock byte FIFO; level alone separates full/empty
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              push,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic              pop,
  output logic      [DATA_W-1:0] rd_data,
  output logic      [AW:0]       level,
  output logic                   full,
  output logic                   empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    full     = (level_q == (AW+1)'(DEPTH));
    empty    = (level_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_feeder : FIFO-buffered byte feeder for a UART transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int GAP_CYCLES = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_tx_feeder_if.slave  bus,
  output logic             busy,
  output logic [AW:0]      level,
  output logic             overflow,
  input  wire logic        clr_overflow
);

  localparam int            CW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_n_q, tx_start_n_d;
  logic [CW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              overflow_q, overflow_d;
  logic              pop;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.wr_valid),
    .wr_data (bus.wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_start_n_d = tx_start_n_q;
    gap_cnt_d    = gap_cnt_q;
    pop          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          tx_data_d    = rd_data;
          tx_start_n_d = 1'b0;
          pop          = 1'b1;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        tx_start_n_d = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.tx_done) begin
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A dropped write outranks a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.wr_valid && full) overflow_d = 1'b1;
    else if (clr_overflow)    overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tx_data_q    <= '0;
      tx_start_n_q <= 1'b1;
      gap_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_start_n_q <= tx_start_n_d;
      gap_cnt_q    <= gap_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.wr_ready   = !full;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start_n = tx_start_n_q;
  assign busy           = (state_q != ST_IDLE) || !empty;
  assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_feeder : directed + randomized bench with a queue-based model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr0 = 1'b0, clr4 = 1'b0;
  logic [4:0] level0, level4;
  logic       busy0, busy4, ovf0, ovf4;

  uart_tx_feeder_if i0 ();
  uart_tx_feeder_if i4 ();

  uart_tx_feeder #(.DEPTH(16), .AW(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(i0.slave), .busy(busy0),
    .level(level0), .overflow(ovf0), .clr_overflow(clr0)
  );

  uart_tx_feeder #(.DEPTH(16), .AW(4), .GAP_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .bus(i4.slave), .busy(busy4),
    .level(level4), .overflow(ovf4), .clr_overflow(clr4)
  );

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0, cyc = 0;
  // Reference model of dut0: accepted-but-not-started bytes, sticky flag, frame-in-flight
  byte unsigned q[$];
  int  mlevel = 0, nstarts = 0, nacc = 0, maxlev = 0;
  bit  mov = 0, mactive = 0, mstart_prev = 0;
  int  done_at = -1, done_lat = 0, last_done = -1;
  bit  rnd_lat = 0, gap_check = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge for both DUTs; model and checks cover dut0.
  task automatic step();
    bit         acc, ovset, done_in, clr_in;
    logic [7:0] wd, expv;
    acc     = i0.wr_valid && (mlevel < 16);
    ovset   = i0.wr_valid && (mlevel >= 16);
    done_in = i0.tx_done;
    clr_in  = clr0;
    wd      = i0.wr_data;
    chk("wr_ready", 32'(i0.wr_ready), 32'(mlevel < 16));
    @(posedge clk); #1; cyc++;
    if (rst) begin
      q.delete(); mlevel = 0; mov = 0; mactive = 0; mstart_prev = 0; done_at = -1;
    end else begin
      if (acc) begin q.push_back(wd); mlevel++; nacc++; end
      if (ovset) mov = 1'b1; else if (clr_in) mov = 1'b0;
      if (mactive && done_in && !mstart_prev) mactive = 1'b0;
      mstart_prev = 1'b0;
      if (i0.tx_start_n === 1'b0) begin
        nstarts++; mstart_prev = 1'b1; mactive = 1'b1;
        if (q.size() == 0) chk("start_without_data", 32'(i0.tx_start_n), 32'd1);
        else begin
          expv = q.pop_front(); mlevel--;
          chk("tx_data", 32'(i0.tx_data), 32'(expv));
        end
        if (gap_check && last_done >= 0) chk("start_after_done", 32'(cyc - last_done), 32'd2);
        if (rnd_lat) done_at = cyc + int'($urandom_range(1, 12));
        else if (done_lat > 0) done_at = cyc + done_lat;
      end
    end
    if (mlevel > maxlev) maxlev = mlevel;
    chk("level", 32'(level0), 32'(mlevel));
    chk("overflow", 32'(ovf0), 32'(mov));
    chk("busy", 32'(busy0), 32'(mactive || (mlevel != 0)));
    i0.wr_valid = 1'b0;
    clr0        = 1'b0;
    i0.tx_done  = (done_at == cyc);
    if (done_at == cyc) last_done = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    int s0, td, s;
    i0.wr_valid = 0; i0.wr_data = 0; i0.tx_done = 0;
    i4.wr_valid = 0; i4.wr_data = 0; i4.tx_done = 0;

    // Reset values
    do_reset();
    chk("rst_start_n", 32'(i0.tx_start_n), 32'd1);
    chk("rst_tx_data", 32'(i0.tx_data), 32'd0);
    chk("rst_level4", 32'(level4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);

    // Single byte latency
    i0.wr_valid = 1; i0.wr_data = 8'hA5; step();
    chk("e0_start_n", 32'(i0.tx_start_n), 32'd1);
    step();
    chk("e1_start_n", 32'(i0.tx_start_n), 32'd0);
    chk("e1_tx_data", 32'(i0.tx_data), 32'hA5);
    step();
    chk("e2_start_n", 32'(i0.tx_start_n), 32'd1);
    chk("e2_tx_data", 32'(i0.tx_data), 32'hA5);
    repeat (9) step();
    chk("wait_busy", 32'(busy0), 32'd1);
    i0.tx_done = 1; last_done = cyc; step();
    chk("done_busy", 32'(busy0), 32'd0);

    // Burst of five with transmitter answering 300 cycles after each start
    do_reset();
    gap_check = 1; done_lat = 300; last_done = -1; s0 = nstarts;
    for (int i = 1; i <= 5; i++) begin
      i0.wr_valid = 1; i0.wr_data = 8'(i); step();
    end
    for (int k = 0; k < 2500 && !(nstarts == s0 + 5 && !busy0); k++) step();
    chk("burst_starts", 32'(nstarts - s0), 32'd5);
    chk("burst_idle", 32'(busy0), 32'd0);
    gap_check = 0; done_lat = 0;

    // Fill to full, overflow, set-wins, clear
    do_reset();
    for (int i = 0; i < 17; i++) begin
      i0.wr_valid = 1; i0.wr_data = 8'($urandom); step();
    end
    chk("full_level", 32'(level0), 32'd16);
    chk("full_ready", 32'(i0.wr_ready), 32'd0);
    i0.wr_valid = 1; i0.wr_data = 8'hEE; step();
    chk("ovf_set", 32'(ovf0), 32'd1);
    chk("ovf_level", 32'(level0), 32'd16);
    i0.wr_valid = 1; clr0 = 1; step();
    chk("ovf_set_wins", 32'(ovf0), 32'd1);
    clr0 = 1; step();
    chk("ovf_clr", 32'(ovf0), 32'd0);

    // Wrap-around: 40 random bytes with random transmitter latency
    do_reset();
    rnd_lat = 1; s0 = nstarts; nacc = 0; maxlev = 0;
    for (int k = 0; k < 3000 && nacc < 40; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        i0.wr_valid = 1; i0.wr_data = 8'($urandom);
      end
      step();
    end
    for (int k = 0; k < 3000 && !(nstarts == s0 + 40 && !busy0); k++) step();
    chk("wrap_accepted", 32'(nacc), 32'd40);
    chk("wrap_starts", 32'(nstarts - s0), 32'd40);
    chk("wrap_maxlev_ok", 32'(maxlev <= 16), 32'd1);
    rnd_lat = 0;

    // Reset while waiting for tx_done with 3 bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      i0.wr_valid = 1; i0.wr_data = 8'(8'h50 + i); step();
    end
    step();
    chk("pre_rst_level", 32'(level0), 32'd3);
    do_reset();
    chk("mid_rst_level", 32'(level0), 32'd0);
    chk("mid_rst_start_n", 32'(i0.tx_start_n), 32'd1);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    s0 = nstarts;
    i0.tx_done = 1; step();
    repeat (10) step();
    chk("no_start_after_rst", 32'(nstarts - s0), 32'd0);

    // Gap of 4 on dut4
    i4.wr_valid = 1; i4.wr_data = 8'h3C; step();
    i4.wr_data = 8'hC3; step();
    i4.wr_valid = 0;
    chk("gap_first_start_n", 32'(i4.tx_start_n), 32'd0);
    chk("gap_first_data", 32'(i4.tx_data), 32'h3C);
    repeat (5) step();
    i4.tx_done = 1; td = cyc; step(); i4.tx_done = 0;
    s = -1;
    for (int k = 0; k < 40 && s < 0; k++) begin
      if (i4.tx_start_n === 1'b0) s = cyc; else step();
    end
    chk("gap_start_delay", 32'(s - td), 32'd6);
    chk("gap_second_data", 32'(i4.tx_data), 32'hC3);
    repeat (3) step();
    i4.tx_done = 1; step(); i4.tx_done = 0;
    repeat (6) step();
    chk("gap_end_busy", 32'(busy4), 32'd0);
    chk("gap_end_level", 32'(level4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffers bytes from the system side in a synchronous FIFO and feeds them one at a time to the UART transmitter.
- Drives the transmitter's active-low start strobe and 8-bit data input.
- Uses the transmitter's one-cycle done pulse to pace frames, with an optional idle gap between frames.
- Sits directly upstream of the UART transmitter in the TX path.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two and at least 2.
- AW, 4, FIFO pointer width; equals log2(DEPTH).
- GAP_CYCLES, 0, idle clock cycles inserted after each tx_done before the next start; 0 means no gap.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_data  in  8  byte to enqueue.
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept a byte; equals (level < DEPTH).
- tx_data  out  8  byte presented to the transmitter's data input.
- tx_start_n  out  1  active-low start strobe to the transmitter; low for exactly one cycle per frame.
- tx_done  in  1  one-cycle frame-complete pulse from the transmitter.
- busy  out  1  high whenever FSM != IDLE or level != 0.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset values, with rst high at an edge:
  - tx_start_n=1, tx_data=0, level=0, rd/wr pointers=0, overflow=0, busy=0, state=IDLE, gap counter=0.
  - FIFO contents are don't-care.
- Write side:
  - A byte is accepted at an edge where wr_valid && wr_ready; it is stored at wr_ptr, then wr_ptr++ (mod DEPTH) and level++.
  - wr_valid && !wr_ready drops the byte and sets overflow. overflow stays set until clr_overflow.
  - If set and clear occur in the same cycle, set wins.
  - No bypass: when full, wr_ready=0 even if a pop happens in the same cycle.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- FSM states:
  - IDLE:
    - If level>0: register tx_data<=mem[rd_ptr] and tx_start_n<=0, then rd_ptr++ and level-- (pop), and go to START.
    - Otherwise stay in IDLE.
  - START: tx_start_n<=1; go to WAIT. tx_start_n is therefore low for exactly the one cycle spent in START.
  - WAIT:
    - tx_data is held stable.
    - On tx_done=1, go to GAP if GAP_CYCLES>0 (counter loaded with GAP_CYCLES-1), else go to IDLE.
  - GAP: counter decrements; at 0 go to IDLE.
- tx_done is ignored in IDLE, START and GAP.
- Latency:
  - A byte written at edge E0 into an empty, idle block is popped at E1.
  - tx_start_n is low between E1 and E2.
  - The transmitter samples start and data at E2.
- Back-to-back frames: the next pop occurs at the first IDLE edge after the WAIT/GAP exit, so tx_start_n is low at most 2+GAP_CYCLES cycles after tx_done.
- Wrap-around: pointers wrap modulo DEPTH; level alone distinguishes full from empty.
- tx_data changes only on a pop.
- Reset mid-frame:
  - The FIFO is flushed and tx_start_n returns high at the reset edge.
  - The transmitter has no reset and completes its current frame; the system must not write for one frame time after rst, because a start issued during a frame in flight is ignored by the transmitter.

Decomposition:
- Package uart_pkg holds:
  - The FSM state encoding (IDLE, START, WAIT, GAP; 2 bits).
  - The constant DATA_W=8.
- Sub-module uart_sync_fifo (storage, pointers, level, full/empty) is instantiated once.
- The FSM, start strobe, gap counter and overflow flag stay in the top level.

Test Plan:
- Single byte: reset, write 0xA5 at E0 -> tx_start_n low only during E1..E2, tx_data=0xA5 from E1; pulse tx_done 10 cycles later -> busy=0 next cycle.
- Burst: write 0x01..0x05 back-to-back with GAP_CYCLES=0, model transmitter returns tx_done 300 cycles after each start -> five start strobes, each tx_start_n low 2 cycles after the preceding tx_done, data in order 0x01..0x05.
- Full/overflow: with tx_done never asserted, write 17 bytes -> first byte popped; level reaches 16, wr_ready=0, byte 18 dropped, overflow=1; assert clr_overflow with no write -> overflow=0.
- Wrap-around: pass 40 bytes through a DEPTH=16 FIFO while keeping level between 1 and 16 -> output order exactly matches input, no loss, level never exceeds 16.
- Gap: GAP_CYCLES=4, two queued bytes -> second tx_start_n low exactly 6 cycles after first tx_done.
- Mid-operation reset: assert rst in WAIT with 3 bytes queued -> next edge level=0, tx_start_n=1, state IDLE; a later tx_done pulse produces no start strobe.
